// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-flash read responder: serves READ/RDID/RDSR from a byte-wide memory read port.
// Optional FAST_READ (0x0B, 8 dummy clocks) is compiled in when SPI_RESP_FAST_READ_EN is defined.
module spi_flash_responder #(
    parameter int          ADDR_W   = 16,
    parameter logic [23:0] JEDEC_ID = 24'h20BA18,
    parameter logic [7:0]  STATUS   = 8'h00
) (
    input  logic              CLOCK,
    input  logic              RESET_n,
    input  logic              SPI_SCK,
    input  logic              SPI_CS_n,
    input  logic              SPI_DI,
    output logic              SPI_DO,
    output logic              SPI_DO_OE,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [7:0]        MEM_RDATA,
    output logic              BUSY,
    output logic              CMD_ERR
);

    // Only the low ADDR_W address bits (and at least the 8 opcode bits) need to be retained.
    localparam int SH_W = (ADDR_W > 8) ? ADDR_W : 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_ID     = 3'd4,
        ST_STATUS = 3'd5,
        ST_IGNORE = 3'd6
`ifdef SPI_RESP_FAST_READ_EN
        ,
        ST_DUMMY  = 3'd7
`endif
    } state_t;

    state_t            state_r;
    logic              sck_meta_r, sck_sync_r, sck_prev_r;
    logic              cs_meta_r, cs_sync_r;
    logic              di_meta_r, di_sync_r;
    logic              sck_rise_s, sck_fall_s;
    logic [4:0]        bit_cnt_r;
    logic [2:0]        out_cnt_r;
    logic [SH_W-2:0]   sh_in_r;
    logic [SH_W-1:0]   sh_next_s;
    logic [7:0]        tx_sh_r;
    logic [7:0]        data_buf_r;
    logic [7:0]        next_byte_s;
    logic [1:0]        id_idx_r;
`ifdef SPI_RESP_FAST_READ_EN
    logic              fast_r;
`endif

    // Two-stage synchronizers for the SPI pins plus the SCK history bit for edge detection.
    always_ff @(posedge CLOCK or negedge RESET_n) begin
        if (!RESET_n) begin
            sck_meta_r <= 1'b0;
            sck_sync_r <= 1'b0;
            sck_prev_r <= 1'b0;
            cs_meta_r  <= 1'b1;
            cs_sync_r  <= 1'b1;
            di_meta_r  <= 1'b0;
            di_sync_r  <= 1'b0;
        end else begin
            sck_meta_r <= SPI_SCK;
            sck_sync_r <= sck_meta_r;
            sck_prev_r <= sck_sync_r;
            cs_meta_r  <= SPI_CS_n;
            cs_sync_r  <= cs_meta_r;
            di_meta_r  <= SPI_DI;
            di_sync_r  <= di_meta_r;
        end
    end

    // SCK edge strobes and the incoming shift value including the bit on this rise.
    always_comb begin
        sck_rise_s = sck_sync_r & ~sck_prev_r;
        sck_fall_s = ~sck_sync_r & sck_prev_r;
        sh_next_s  = {sh_in_r, di_sync_r};
    end

    // Byte loaded into the output shifter at the start of each outgoing byte.
    always_comb begin
        next_byte_s = 8'h00;
        case (state_r)
            ST_DATA:   next_byte_s = data_buf_r;
            ST_STATUS: next_byte_s = STATUS;
            ST_ID: begin
                case (id_idx_r)
                    2'd0:    next_byte_s = JEDEC_ID[23:16];
                    2'd1:    next_byte_s = JEDEC_ID[15:8];
                    default: next_byte_s = JEDEC_ID[7:0];
                endcase
            end
            default:   next_byte_s = 8'h00;
        endcase
    end

    // Protocol FSM with registered pin, memory and status outputs.
    always_ff @(posedge CLOCK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 5'd0;
            out_cnt_r  <= 3'd0;
            sh_in_r    <= '0;
            tx_sh_r    <= 8'h00;
            data_buf_r <= 8'h00;
            id_idx_r   <= 2'd0;
`ifdef SPI_RESP_FAST_READ_EN
            fast_r     <= 1'b0;
`endif
            SPI_DO     <= 1'b0;
            SPI_DO_OE  <= 1'b0;
            MEM_REQ    <= 1'b0;
            MEM_ADDR   <= '0;
            BUSY       <= 1'b0;
            CMD_ERR    <= 1'b0;
        end else begin
            CMD_ERR <= 1'b0;
            // A request survives an abort; its data simply lands in an unused buffer.
            if (MEM_REQ && MEM_ACK) begin
                MEM_REQ    <= 1'b0;
                data_buf_r <= MEM_RDATA;
            end
            if ((state_r != ST_IDLE) && cs_sync_r) begin
                state_r   <= ST_IDLE;
                SPI_DO_OE <= 1'b0;
                SPI_DO    <= 1'b0;
                BUSY      <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (!cs_sync_r && !MEM_REQ) begin
                            state_r   <= ST_CMD;
                            BUSY      <= 1'b1;
                            bit_cnt_r <= 5'd0;
                            out_cnt_r <= 3'd0;
                            id_idx_r  <= 2'd0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise_s) begin
                            sh_in_r   <= sh_next_s[SH_W-2:0];
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                            if (bit_cnt_r == 5'd7) begin
                                bit_cnt_r <= 5'd0;
`ifdef SPI_RESP_FAST_READ_EN
                                fast_r    <= (sh_next_s[7:0] == 8'h0B);
`endif
                                case (sh_next_s[7:0])
                                    8'h03:   state_r <= ST_ADDR;
                                    8'h9F:   state_r <= ST_ID;
                                    8'h05:   state_r <= ST_STATUS;
`ifdef SPI_RESP_FAST_READ_EN
                                    8'h0B:   state_r <= ST_ADDR;
`endif
                                    default: begin
                                        state_r <= ST_IGNORE;
                                        CMD_ERR <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise_s) begin
                            sh_in_r   <= sh_next_s[SH_W-2:0];
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                            if (bit_cnt_r == 5'd23) begin
                                bit_cnt_r <= 5'd0;
                                MEM_ADDR  <= sh_next_s[ADDR_W-1:0];
                                MEM_REQ   <= 1'b1;
`ifdef SPI_RESP_FAST_READ_EN
                                state_r   <= fast_r ? ST_DUMMY : ST_DATA;
`else
                                state_r   <= ST_DATA;
`endif
                            end
                        end
                    end
`ifdef SPI_RESP_FAST_READ_EN
                    ST_DUMMY: begin
                        if (sck_rise_s) begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                            if (bit_cnt_r == 5'd7) begin
                                bit_cnt_r <= 5'd0;
                                state_r   <= ST_DATA;
                            end
                        end
                    end
`endif
                    ST_DATA, ST_ID, ST_STATUS: begin
                        if (sck_fall_s) begin
                            SPI_DO_OE <= 1'b1;
                            out_cnt_r <= out_cnt_r + 3'd1;
                            if (out_cnt_r == 3'd0) begin
                                SPI_DO  <= next_byte_s[7];
                                tx_sh_r <= {next_byte_s[6:0], 1'b0};
                                if (state_r == ST_ID) begin
                                    id_idx_r <= (id_idx_r == 2'd2) ? 2'd0 : id_idx_r + 2'd1;
                                end
                            end else begin
                                SPI_DO  <= tx_sh_r[7];
                                tx_sh_r <= {tx_sh_r[6:0], 1'b0};
                            end
                        end else if (sck_rise_s && (state_r == ST_DATA) && (out_cnt_r == 3'd1)) begin
                            // The first bit of this byte is out: fetch the next one well before it is needed.
                            MEM_ADDR <= MEM_ADDR + ADDR_W'(1);
                            MEM_REQ  <= 1'b1;
                        end
                    end
                    ST_IGNORE: begin
                        state_r <= ST_IGNORE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        BUSY    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: acts as SPI master and memory, compares against a byte-level model.
module tb_spi_flash_responder;

    logic        CLOCK, RESET_n, SPI_SCK, SPI_CS_n, SPI_DI;
    logic        SPI_DO, SPI_DO_OE, MEM_REQ, MEM_ACK, BUSY, CMD_ERR;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_RDATA;

    logic [7:0]  mem [65536];
    logic [7:0]  rx_q [$];
    logic [23:0] jedec = 24'h20BA18;
    int          errors = 0;
    int          checks = 0;
    int          req_rises = 0;
    int          cmd_err_cnt = 0;

    spi_flash_responder #(.ADDR_W(16), .JEDEC_ID(24'h20BA18), .STATUS(8'h00)) dut (
        .CLOCK(CLOCK), .RESET_n(RESET_n), .SPI_SCK(SPI_SCK), .SPI_CS_n(SPI_CS_n), .SPI_DI(SPI_DI),
        .SPI_DO(SPI_DO), .SPI_DO_OE(SPI_DO_OE), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
        .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA), .BUSY(BUSY), .CMD_ERR(CMD_ERR)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: acknowledges each request one or two cycles after it rises.
    initial begin
        logic pend;
        pend = 1'b0;
        MEM_ACK = 1'b0;
        MEM_RDATA = 8'h00;
        forever begin
            @(posedge CLOCK);
            #1;
            if (MEM_ACK) begin
                MEM_ACK = 1'b0;
            end else if (MEM_REQ) begin
                if (pend || ($urandom_range(1, 0) == 0)) begin
                    MEM_ACK = 1'b1;
                    MEM_RDATA = mem[MEM_ADDR];
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                end
            end
        end
    end

    // Per-cycle checks of the memory port and status outputs.
    initial begin
        logic        prev_req, prev_err;
        logic [15:0] prev_addr;
        prev_req = 1'b0;
        prev_err = 1'b0;
        prev_addr = 16'h0000;
        forever begin
            @(negedge CLOCK);
            if (!RESET_n) begin
                prev_req = 1'b0;
                prev_err = 1'b0;
            end else begin
                if (MEM_REQ && prev_req) check("mem_addr_stable", MEM_ADDR, prev_addr);
                if (MEM_REQ && !prev_req) req_rises++;
                if (CMD_ERR) begin
                    check("cmd_err_single_cycle", prev_err, 0);
                    cmd_err_cnt++;
                end
                if (SPI_DO_OE) check("oe_implies_busy", BUSY, 1);
                prev_req = MEM_REQ;
                prev_addr = MEM_ADDR;
                prev_err = CMD_ERR;
            end
        end
    end

    task automatic sck_cycle(input logic di, output logic do_v, output logic oe_v);
        int h;
        SPI_DI = di;
        h = $urandom_range(9, 6);
        repeat (h) @(posedge CLOCK);
        #1;
        do_v = SPI_DO;
        oe_v = SPI_DO_OE;
        #1;
        SPI_SCK = 1'b1;
        h = $urandom_range(9, 6);
        repeat (h) @(posedge CLOCK);
        #2;
        SPI_SCK = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, inout logic oe_any);
        logic d, o;
        for (int i = 7; i >= 0; i--) begin
            sck_cycle(b[i], d, o);
            oe_any = oe_any | o;
        end
    endtask

    task automatic recv_byte(output logic [7:0] b, output logic oe_all);
        logic d, o;
        b = 8'h00;
        oe_all = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sck_cycle(1'b0, d, o);
            b = {b[6:0], d};
            oe_all = oe_all & o;
        end
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] a, output logic oe_any);
        oe_any = 1'b0;
        send_byte(op, oe_any);
        send_byte(a[23:16], oe_any);
        send_byte(a[15:8], oe_any);
        send_byte(a[7:0], oe_any);
    endtask

    task automatic cs_low();
        @(posedge CLOCK);
        #2;
        SPI_CS_n = 1'b0;
        repeat (4) @(posedge CLOCK);
    endtask

    task automatic cs_high();
        @(posedge CLOCK);
        #2;
        SPI_CS_n = 1'b1;
        repeat (10) @(posedge CLOCK);
        #1;
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        logic        oe_any, oe_all;
        logic [7:0]  b;
        logic [15:0] ea;
        rx_q.delete();
        cs_low();
        send_hdr(8'h03, a, oe_any);
        check("read_oe_in_header", oe_any, 0);
        for (int k = 0; k < n; k++) begin
            recv_byte(b, oe_all);
            ea = a[15:0] + 16'(k);
            check("read_byte", b, mem[ea]);
            check("read_oe_in_data", oe_all, 1);
            rx_q.push_back(b);
        end
        cs_high();
        ea = a[15:0] + 16'(n);
        check("read_final_addr", MEM_ADDR, ea);
        check("read_end_idle", {BUSY, SPI_DO_OE}, 0);
    endtask

    task automatic do_id(input int n, input logic pin);
        logic       oe_any, oe_all, d, o;
        logic [7:0] b;
        int         r0;
        logic [7:0] pins [3];
        pins[0] = 8'h20; pins[1] = 8'hBA; pins[2] = 8'h18;
        r0 = req_rises;
        cs_low();
        oe_any = 1'b0;
        send_byte(8'h9F, oe_any);
        check("id_oe_in_cmd", oe_any, 0);
        for (int k = 0; k < n; k++) begin
            recv_byte(b, oe_all);
            check("id_byte", b, jedec[23 - 8 * (k % 3) -: 8]);
            if (pin) check("id_byte_literal", b, pins[k % 3]);
            check("id_oe_in_data", oe_all, 1);
        end
        cs_high();
        check("id_no_mem_req", req_rises - r0, 0);
    endtask

    task automatic do_status(input int n);
        logic       oe_any, oe_all;
        logic [7:0] b;
        cs_low();
        oe_any = 1'b0;
        send_byte(8'h05, oe_any);
        check("status_oe_in_cmd", oe_any, 0);
        for (int k = 0; k < n; k++) begin
            recv_byte(b, oe_all);
            check("status_byte", b, 8'h00);
            check("status_oe_in_data", oe_all, 1);
        end
        cs_high();
        check("status_oe_after_cs", SPI_DO_OE, 0);
    endtask

    task automatic do_bad(input logic [7:0] op);
        logic       oe_any;
        int         e0;
        e0 = cmd_err_cnt;
        cs_low();
        oe_any = 1'b0;
        send_byte(op, oe_any);
        send_byte(8'hFF, oe_any);
        send_byte(8'h00, oe_any);
        cs_high();
        check("bad_op_cmd_err_once", cmd_err_cnt - e0, 1);
        check("bad_op_oe_low", oe_any, 0);
    endtask

    initial begin
        logic       oe_any, oe_all, d, o;
        logic [7:0] b, op;
        int         kind, e0;
        logic [7:0] pin4 [4];
        pin4[0] = 8'hDE; pin4[1] = 8'hAD; pin4[2] = 8'hBE; pin4[3] = 8'hEF;

        RESET_n = 1'b0;
        SPI_SCK = 1'b0;
        SPI_CS_n = 1'b1;
        SPI_DI = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0100] = 8'hDE; mem[16'h0101] = 8'hAD; mem[16'h0102] = 8'hBE; mem[16'h0103] = 8'hEF;
        mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hA5;

        repeat (3) @(posedge CLOCK);
        #1;
        check("rst_do", SPI_DO, 0);
        check("rst_do_oe", SPI_DO_OE, 0);
        check("rst_mem_req", MEM_REQ, 0);
        check("rst_mem_addr", MEM_ADDR, 0);
        check("rst_busy", BUSY, 0);
        check("rst_cmd_err", CMD_ERR, 0);
        #1;
        RESET_n = 1'b1;
        repeat (5) @(posedge CLOCK);

        // READ of the boot image, pinned to literal bytes
        do_read(24'h000100, 4);
        for (int k = 0; k < 4; k++) check("read_literal", rx_q[k], pin4[k]);
        check("read_literal_final_addr", MEM_ADDR, 16'h0104);

        do_id(6, 1'b1);
        do_status(2);

        // Address wrap at the top of memory
        do_read(24'h00FFFF, 2);
        check("wrap_byte0", rx_q[0], 8'h5A);
        check("wrap_byte1", rx_q[1], 8'hA5);

        // Abort after three data bits
        cs_low();
        send_hdr(8'h03, 24'h000200, oe_any);
        b = 8'h00;
        for (int i = 0; i < 3; i++) begin
            sck_cycle(1'b0, d, o);
            b = {b[6:0], d};
        end
        check("abort_partial_bits", b[2:0], mem[16'h0200][7:5]);
        @(posedge CLOCK);
        #2;
        SPI_CS_n = 1'b1;
        repeat (4) @(posedge CLOCK);
        #1;
        check("abort_oe_low", SPI_DO_OE, 0);
        check("abort_busy_low", BUSY, 0);
        repeat (8) @(posedge CLOCK);
        check("abort_prefetch_addr", MEM_ADDR, 16'h0201);
        do_read(24'h000000, 1);
        check("after_abort_mem0", rx_q[0], 8'hA5);

        do_bad(8'h02);

`ifdef SPI_RESP_FAST_READ_EN
        cs_low();
        send_hdr(8'h0B, 24'h000100, oe_any);
        send_byte(8'h00, oe_any);
        check("fast_oe_in_header", oe_any, 0);
        recv_byte(b, oe_all);
        check("fast_byte0", b, 8'hDE);
        recv_byte(b, oe_all);
        check("fast_byte1", b, 8'hAD);
        check("fast_oe_in_data", oe_all, 1);
        cs_high();
`else
        e0 = cmd_err_cnt;
        cs_low();
        send_hdr(8'h0B, 24'h000100, oe_any);
        send_byte(8'h00, oe_any);
        recv_byte(b, oe_all);
        oe_any = oe_any | oe_all;
        cs_high();
        check("fast_disabled_cmd_err", cmd_err_cnt - e0, 1);
        check("fast_disabled_no_data", oe_any, 0);
`endif

        // Randomized command mix against the model
        for (int it = 0; it < 16; it++) begin
            kind = $urandom_range(3, 0);
            case (kind)
                0: do_read(24'($urandom), $urandom_range(4, 1));
                1: do_id($urandom_range(5, 1), 1'b0);
                2: do_status($urandom_range(3, 1));
                default: begin
                    do begin
                        op = 8'($urandom);
                    end while (op == 8'h03 || op == 8'h9F || op == 8'h05 || op == 8'h0B);
                    do_bad(op);
                end
            endcase
        end

        // Asynchronous reset in the middle of a READ
        cs_low();
        send_hdr(8'h03, 24'h000100, oe_any);
        recv_byte(b, oe_all);
        check("pre_reset_byte", b, 8'hDE);
        for (int i = 0; i < 3; i++) sck_cycle(1'b0, d, o);
        @(posedge CLOCK);
        #3;
        RESET_n = 1'b0;
        #1;
        check("midrst_do", SPI_DO, 0);
        check("midrst_oe", SPI_DO_OE, 0);
        check("midrst_req", MEM_REQ, 0);
        check("midrst_addr", MEM_ADDR, 0);
        check("midrst_busy", BUSY, 0);
        SPI_CS_n = 1'b1;
        repeat (5) @(posedge CLOCK);
        #2;
        RESET_n = 1'b1;
        repeat (5) @(posedge CLOCK);
        do_read(24'h000100, 2);
        check("post_reset_byte0", rx_q[0], 8'hDE);
        check("post_reset_byte1", rx_q[1], 8'hAD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI serial-flash responder (target side). The system's SPI flash master boots from it on-board or in simulation in place of the external flash part.
- Serves the read subset of the N25Q command set from a byte-wide memory read port, e.g. a BRAM preloaded with a boot image.
- Mode 0 only (CPOL=0, CPHA=0), single-bit I/O: commands arrive on DQ0, data leaves on DQ1.
- SPI pins are oversampled in the system clock domain.

Parameters:
- ADDR_W, 16, memory address width; the low ADDR_W bits of the 24-bit SPI address are used.
- JEDEC_ID, 24'h20BA18, bytes returned by RDID (0x9F), MSB byte first.
- STATUS, 8'h00, byte returned by RDSR (0x05); WIP is always 0.

Ports:
- CLOCK  in  1  system clock; all logic is on its rising edge.
- RESET_n  in  1  asynchronous active-low reset.
- SPI_SCK  in  1  serial clock from master; asynchronous, 2-FF synchronized.
- SPI_CS_n  in  1  chip select, active low; 2-FF synchronized.
- SPI_DI  in  1  master-out data (DQ0); 2-FF synchronized.
- SPI_DO  out  1  responder-out data (DQ1).
- SPI_DO_OE  out  1  output enable for SPI_DO pad tristate.
- MEM_REQ  out  1  read request, held until MEM_ACK.
- MEM_ADDR  out  ADDR_W  byte address, stable while MEM_REQ=1.
- MEM_ACK  in  1  one-cycle pulse; MEM_RDATA is valid in the same cycle.
- MEM_RDATA  in  8  read byte.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- CMD_ERR  out  1  one-cycle pulse when an unsupported opcode completes.

Behaviour:
- Reset values: SPI_DO=0, SPI_DO_OE=0, MEM_REQ=0, MEM_ADDR=0, BUSY=0, CMD_ERR=0. The FSM resets to IDLE, and the synchronizers reset to SCK=0, CS_n=1.
- Timing requirements:
  - SCK high and low phases are each ≥6 CLOCK cycles.
  - MEM_ACK arrives ≤2 cycles after MEM_REQ rises.
  - Edge detection (rise/fall) is performed on the synchronized SCK, with 3 cycles of latency from the pin.
- Input sampling: bits are shifted in MSB-first on each detected SCK rise.
- Output driving:
  - SPI_DO is updated on each detected SCK fall.
  - The first output bit is driven on the fall that follows the last command/address/dummy bit.
- Synchronized CS_n falling: reset bit counter, go to CMD.
- CMD: after 8 rises, decode the opcode.
  - 0x03 → ADDR.
  - 0x9F → ID.
  - 0x05 → STATUS.
  - 0x0B → ADDR only with the optional feature enabled, otherwise treated as an unknown opcode.
  - Any other opcode → IGNORE and pulse CMD_ERR.
- ADDR: shift in 24 bits.
  - On the 24th rise, load MEM_ADDR = addr[ADDR_W-1:0] and assert MEM_REQ.
  - On MEM_ACK, capture the byte into the output shift register and drop MEM_REQ.
  - Next state is DATA (0x03) or DUMMY (0x0B).
- DUMMY: count 8 rises, then DATA. The prefetched byte is held until then.
- DATA:
  - Assert SPI_DO_OE, then shift the byte out MSB-first, one bit per fall.
  - On the 8th bit's fall, the next byte must already be loaded. To achieve this, issue the prefetch for MEM_ADDR+1 on the rise of bit 0 of the current byte.
  - MEM_ADDR wraps from 2^ADDR_W-1 to 0.
- ID: shift out the JEDEC_ID bytes in order. After 3 bytes, repeat from byte 0.
- STATUS: shift out STATUS repeatedly for as long as CS_n is low.
- IGNORE: SPI_DO_OE stays 0 and all SCK activity is ignored until CS_n rises.
- Synchronized CS_n rising, in any state and at any bit position:
  - Go to IDLE and drop SPI_DO_OE on the same cycle.
  - An outstanding MEM_REQ stays asserted until MEM_ACK, then the data is discarded.
  - A new CS_n fall is not accepted while that request is pending; it is deferred 1–2 cycles.
- Simultaneous CS_n rise and SCK edge: CS_n has priority.
- RESET_n asserted mid-transfer: outputs return to their reset values immediately (asynchronously).

Optional Feature:
- Macro SPI_RESP_FAST_READ_EN.
- Defined: opcode 0x0B (FAST_READ) is accepted, with 24 address bits and 8 dummy clocks before data.
- Undefined: 0x0B is an unknown opcode (IGNORE + CMD_ERR), and the DUMMY state and its counter are not synthesized.

Test Plan:
- Memory preloaded with mem[0x0100..0x0103]=DE AD BE EF. Send 0x03, addr 0x000100, then 32 clocks → DO returns DE AD BE EF. MEM_ADDR steps 0x100→0x104 (final prefetch to 0x104).
- Send 0x9F, then 48 clocks → 20 BA 18 20 BA 18. Zero MEM_REQ pulses.
- Send 0x05, then 16 clocks → 00 00, with SPI_DO_OE high only during the data phase.
- Wrap: ADDR_W=16, mem[0xFFFF]=0x5A, mem[0]=0xA5. Send 0x03, addr 0x00FFFF → 5A A5.
- Abort and error:
  - CS_n raised after 3 data bits of a READ → SPI_DO_OE=0 within 4 cycles of the pin edge.
  - A following 0x03 to addr 0x000000 returns mem[0] correctly.
  - Opcode 0x02 → CMD_ERR pulses once, and DO_OE stays 0.
- FAST_READ: with SPI_RESP_FAST_READ_EN, send 0x0B, addr 0x000100, 8 dummy, 16 clocks → DE AD. Without the macro: CMD_ERR=1 and no data.
